// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: gathers four beats into one frame and presents
// the lanes in parallel behind a valid/ready output register with sticky error flags.
module tdm_demux4 #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [WIDTH-1:0] out_d0,
    output logic [WIDTH-1:0] out_d1,
    output logic [WIDTH-1:0] out_d2,
    output logic [WIDTH-1:0] out_d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       slot,
    output logic             err_sync,
    output logic             overflow,
    input  logic             clr_flags
);

    logic [WIDTH-1:0] stg0_r;
    logic [WIDTH-1:0] stg1_r;
    logic [WIDTH-1:0] stg2_r;

    logic [1:0] eff_slot_s;
    logic       complete_s;
    logic       load_ok_s;
    logic       load_s;
    logic       misalign_s;
    logic       drop_s;
    logic       accept_s;

    // Beat classification: effective slot, frame completion, load and error conditions.
    always_comb begin
        eff_slot_s = slot;
        complete_s = 1'b0;
        misalign_s = 1'b0;
        if (in_valid) begin
            // A qualified SOF forces slot 0; a partial frame is abandoned by overwriting lane 0 onward.
            if (in_sof) begin
                eff_slot_s = 2'd0;
                misalign_s = (slot != 2'd0);
            end else begin
                eff_slot_s = slot;
                misalign_s = 1'b0;
            end
            complete_s = (eff_slot_s == 2'd3);
        end else begin
            eff_slot_s = slot;
            complete_s = 1'b0;
            misalign_s = 1'b0;
        end
        load_ok_s = !out_valid || out_ready;
        load_s    = complete_s && load_ok_s;
        drop_s    = complete_s && !load_ok_s;
        accept_s  = out_valid && out_ready;
    end

    // Slot counter, staging lanes, output frame register and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= 2'd0;
            stg0_r    <= '0;
            stg1_r    <= '0;
            stg2_r    <= '0;
            out_d0    <= '0;
            out_d1    <= '0;
            out_d2    <= '0;
            out_d3    <= '0;
            out_valid <= 1'b0;
            err_sync  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (in_valid) begin
                slot <= eff_slot_s + 2'd1;
                case (eff_slot_s)
                    2'd0:    stg0_r <= in_data;
                    2'd1:    stg1_r <= in_data;
                    2'd2:    stg2_r <= in_data;
                    default: ;
                endcase
            end

            // Lane 3 bypasses staging so the frame loads on the edge of its last beat.
            if (load_s) begin
                out_d0    <= stg0_r;
                out_d1    <= stg1_r;
                out_d2    <= stg2_r;
                out_d3    <= in_data;
                out_valid <= 1'b1;
            end else if (accept_s) begin
                out_valid <= 1'b0;
            end

            // Set dominates a coincident clear.
            err_sync <= misalign_s | (err_sync & ~clr_flags);
            overflow <= drop_s     | (overflow & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed testbench for tdm_demux4 (WIDTH=2) with hand-computed expected values.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic [1:0] out_d0, out_d1, out_d2, out_d3;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] slot;
    logic       err_sync;
    logic       overflow;
    logic       clr_flags;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux4 #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_d2    (out_d2),
        .out_d3    (out_d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .err_sync  (err_sync),
        .overflow  (overflow),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One beat: inputs are driven 1 time unit after an edge, outputs read 1 unit after the next.
    task automatic send(input logic [1:0] d, input logic sof);
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = sof;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] c, input logic [1:0] d);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_d0"}, 32'(out_d0), 32'(a));
        check_eq({tag, "_d1"}, 32'(out_d1), 32'(b));
        check_eq({tag, "_d2"}, 32'(out_d2), 32'(c));
        check_eq({tag, "_d3"}, 32'(out_d3), 32'(d));
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 2'd0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        #3;
        check_eq("rst_slot", 32'(slot), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_d0", 32'(out_d0), 32'd0);
        check_eq("rst_err", 32'(err_sync), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Aligned frame, consumer always ready.
        send(2'b01, 1'b1);
        send(2'b10, 1'b0);
        send(2'b11, 1'b0);
        check_eq("al_pre_valid", 32'(out_valid), 32'd0);
        send(2'b00, 1'b0);
        check_frame("al", 2'd1, 2'd2, 2'd3, 2'd0);
        idle(1);
        check_eq("al_one_cycle", 32'(out_valid), 32'd0);

        // Same frame with two idle cycles between beats; slot walks 0,1,2,3,0.
        check_eq("gap_slot0", 32'(slot), 32'd0);
        send(2'b01, 1'b1);
        idle(2);
        check_eq("gap_slot1", 32'(slot), 32'd1);
        send(2'b10, 1'b0);
        idle(2);
        check_eq("gap_slot2", 32'(slot), 32'd2);
        send(2'b11, 1'b0);
        idle(2);
        check_eq("gap_slot3", 32'(slot), 32'd3);
        send(2'b00, 1'b0);
        check_frame("gap", 2'd1, 2'd2, 2'd3, 2'd0);
        check_eq("gap_slot_wrap", 32'(slot), 32'd0);
        check_eq("gap_err", 32'(err_sync), 32'd0);
        check_eq("gap_ovf", 32'(overflow), 32'd0);
        idle(1);

        // Backpressure: frame A held, frame B dropped with overflow.
        out_ready = 1'b0;
        send(2'd1, 1'b1); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
        check_frame("bpA", 2'd1, 2'd2, 2'd3, 2'd0);
        check_eq("bpA_ovf", 32'(overflow), 32'd0);
        send(2'd3, 1'b1); send(2'd2, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0);
        check_frame("bp_hold", 2'd1, 2'd2, 2'd3, 2'd0);
        check_eq("bp_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        idle(1);
        check_eq("bp_accept", 32'(out_valid), 32'd0);
        check_eq("bp_ovf_sticky", 32'(overflow), 32'd1);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        check_eq("bp_clr", 32'(overflow), 32'd0);

        // Misaligned SOF: two beats, then SOF restarts the frame at lane 0.
        send(2'd1, 1'b0);
        send(2'd1, 1'b0);
        check_eq("mis_err_pre", 32'(err_sync), 32'd0);
        send(2'd2, 1'b1);
        check_eq("mis_err", 32'(err_sync), 32'd1);
        check_eq("mis_slot", 32'(slot), 32'd1);
        check_eq("mis_no_out", 32'(out_valid), 32'd0);
        send(2'd3, 1'b0);
        send(2'd0, 1'b0);
        check_eq("mis_no_out2", 32'(out_valid), 32'd0);
        send(2'd1, 1'b0);
        check_frame("mis", 2'd2, 2'd3, 2'd0, 2'd1);
        idle(1);
        check_eq("mis_single", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-frame, then a frame without SOF.
        send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
        check_eq("mr_slot_pre", 32'(slot), 32'd3);
        rst = 1'b1;
        #2;
        check_eq("mr_slot", 32'(slot), 32'd0);
        check_eq("mr_err", 32'(err_sync), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'd3, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd0, 1'b0);
        check_frame("mr", 2'd3, 2'd1, 2'd2, 2'd0);
        idle(1);

        // Flag set coinciding with clear: set wins; then a lone clear drops both.
        out_ready = 1'b0;
        send(2'd1, 1'b1); send(2'd1, 1'b0); send(2'd1, 1'b0); send(2'd1, 1'b0);
        send(2'd2, 1'b1); send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
        check_eq("fc_ovf", 32'(overflow), 32'd1);
        check_frame("fc_hold", 2'd1, 2'd1, 2'd1, 2'd1);
        send(2'd3, 1'b0);
        clr_flags = 1'b1;
        send(2'd3, 1'b1);
        clr_flags = 1'b0;
        check_eq("fc_set_wins", 32'(err_sync), 32'd1);
        check_eq("fc_ovf_clr", 32'(overflow), 32'd0);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        check_eq("fc_err_clr", 32'(err_sync), 32'd0);
        check_eq("fc_ovf_clr2", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
